// File: rtl/wf_rr_picker_pkg.sv
// ============================================================================
//  Module   : wf_rr_picker_pkg
//  Brief    : Shared pick-mode constants and index-width helper for the picker.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package wf_rr_picker_pkg;

    localparam int PICK_MODE_FIXED = 0;
    localparam int PICK_MODE_RR    = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wf_rr_picker_prio_find_first.sv
// ============================================================================
//  Module   : prio_find_first
//  Brief    : Combinational first-set-bit search starting at an arbitrary index.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module prio_find_first #(
    parameter int N     = 40,
    parameter int IDX_W = 6
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam int c_POS_W = IDX_W + 1;

    logic [2*N-1:0]     w_dbl;
    logic [2*N-1:0]     w_masked;
    logic [c_POS_W-1:0] w_pos;

    // Unrolling the vector twice turns the circular scan into a linear one.
    assign w_dbl = {vec, vec};

    always_comb begin
        w_masked = w_dbl;
        for (int i = 0; i < 2*N; i++) begin
            if (i < int'(start)) w_masked[i] = 1'b0;
        end
    end

    always_comb begin
        w_pos = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_masked[i]) w_pos = c_POS_W'(i);
        end
    end

    assign found = |vec;
    assign idx   = (w_pos >= c_POS_W'(N)) ? IDX_W'(w_pos - c_POS_W'(N)) : IDX_W'(w_pos);

endmodule

`default_nettype wire

// File: rtl/wf_rr_picker.sv
// ============================================================================
//  Module   : wf_rr_picker
//  Brief    : Registered fixed-priority / round-robin index picker with
//             valid/ready output handshake.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module wf_rr_picker
    import wf_rr_picker_pkg::*;
#(
    parameter int NUM_REQ = 40,
    parameter int IDX_W   = clog2(NUM_REQ),
    parameter int RR_MODE = PICK_MODE_RR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [NUM_REQ-1:0] out_onehot,
    output logic [IDX_W-1:0]   rr_ptr
);

    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_onehot;

    logic               w_accept;
    logic               w_load;
    logic               w_found;
    logic [NUM_REQ-1:0] w_cand;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_ptr_nxt;

    assign w_accept = r_valid & out_ready;
    assign w_load   = ~r_valid | w_accept;

    // The pick being handed over is hidden so a level request is not granted twice.
    assign w_cand = w_accept ? (req & ~r_onehot) : req;

    generate
        if (RR_MODE == PICK_MODE_RR) begin : g_rr
            assign w_start   = r_rr_ptr;
            assign w_ptr_nxt = !w_accept ? r_rr_ptr :
                               (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + IDX_W'(1);
        end else begin : g_fixed
            assign w_start   = '0;
            assign w_ptr_nxt = '0;
        end
    endgenerate

    prio_find_first #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_find (
        .vec   (w_cand),
        .start (w_start),
        .found (w_found),
        .idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
            if (w_load) begin
                r_valid  <= w_found;
                r_onehot <= w_found ? (NUM_REQ'(1) << w_pick) : '0;
                if (w_found) r_idx <= w_pick;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign rr_ptr     = r_rr_ptr;

endmodule

`default_nettype wire
